// File: rtl/clock_route_div_pkg.sv
// Shared types and constants for the fractional clock-divider configuration path.
package clock_route_div_pkg;

    localparam int unsigned RATIO_W = 8;

    typedef enum logic [1:0] {
        OP_UPDATE  = 2'b00,
        OP_ENABLE  = 2'b01,
        OP_DISABLE = 2'b10,
        OP_RSVD    = 2'b11
    } req_op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_BAD_CFG = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_BAD_OP  = 2'b11
    } rsp_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPD_SETUP,
        S_UPD_RAISE,
        S_UPD_LOWER,
        S_EN_WAIT,
        S_RESP
    } state_e;

    // A ratio is unusable if the integer part is zero or the fraction is not proper.
    function automatic logic cfg_is_bad(input logic [RATIO_W-1:0] mfi_v,
                                        input logic [RATIO_W-1:0] mfn_v,
                                        input logic [RATIO_W-1:0] mfd_v);
        return (mfi_v == '0)
            || ((mfd_v == '0) && (mfn_v != '0))
            || ((mfd_v != '0) && (mfn_v >= mfd_v));
    endfunction

endpackage

// File: rtl/clock_logic_cross_sync_0.sv
// Two-flop synchronizer for a single asynchronous level.
module clock_logic_cross_sync_0 (
    input  logic clock,
    input  logic async_resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clock_route_div_cfg_requester.sv
// Config-domain initiator: drives ratio/update/enable levels to the divider
// and completes a four-phase handshake per command, returning one status pulse.
module clock_route_div_cfg_requester
    import clock_route_div_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clock,
    input  logic               async_resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [RATIO_W-1:0] req_mfi,
    input  logic [RATIO_W-1:0] req_mfn,
    input  logic [RATIO_W-1:0] req_mfd,
    output logic               rsp_valid,
    output logic [1:0]         rsp_status,
    output logic               busy,
    output logic               async_enable,
    input  logic               async_enable_ack,
    output logic               async_update,
    input  logic               async_update_ack,
    output logic [RATIO_W-1:0] mfi,
    output logic [RATIO_W-1:0] mfn,
    output logic [RATIO_W-1:0] mfd
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               upd_q, upd_d;
    logic               rsp_valid_q;
    rsp_status_e        status_q, status_d;
    logic [RATIO_W-1:0] mfi_q, mfi_d, mfn_q, mfn_d, mfd_q, mfd_d;
    logic               en_ack_s, upd_ack_s;
    logic               timed_out;

    clock_logic_cross_sync_0 u_sync_en_ack (
        .clock        (clock),
        .async_resetn (async_resetn),
        .d            (async_enable_ack),
        .q            (en_ack_s)
    );

    clock_logic_cross_sync_0 u_sync_upd_ack (
        .clock        (clock),
        .async_resetn (async_resetn),
        .d            (async_update_ack),
        .q            (upd_ack_s)
    );

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        upd_d    = upd_q;
        status_d = status_q;
        mfi_d    = mfi_q;
        mfn_d    = mfn_q;
        mfd_d    = mfd_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    case (req_op)
                        OP_UPDATE: begin
                            if (cfg_is_bad(req_mfi, req_mfn, req_mfd)) begin
                                status_d = ST_BAD_CFG;
                                state_d  = S_RESP;
                            end else begin
                                mfi_d   = req_mfi;
                                mfn_d   = req_mfn;
                                mfd_d   = req_mfd;
                                state_d = S_UPD_SETUP;
                            end
                        end
                        OP_ENABLE, OP_DISABLE: begin
                            en_d    = (req_op == OP_ENABLE);
                            cnt_d   = '0;
                            state_d = S_EN_WAIT;
                        end
                        default: begin
                            status_d = ST_BAD_OP;
                            state_d  = S_RESP;
                        end
                    endcase
                end
            end
            S_UPD_SETUP: begin
                upd_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_UPD_RAISE;
            end
            S_UPD_RAISE: begin
                if (upd_ack_s) begin
                    upd_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_UPD_LOWER;
                end else if (timed_out) begin
                    upd_d    = 1'b0;
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UPD_LOWER: begin
                if (!upd_ack_s) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (timed_out) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EN_WAIT: begin
                if (en_ack_s == en_q) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (timed_out) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // rsp_valid is registered alongside the RESP state so it lasts exactly that cycle.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            upd_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            status_q    <= ST_OK;
            mfi_q       <= '0;
            mfn_q       <= '0;
            mfd_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            upd_q       <= upd_d;
            rsp_valid_q <= (state_d == S_RESP);
            status_q    <= status_d;
            mfi_q       <= mfi_d;
            mfn_q       <= mfn_d;
            mfd_q       <= mfd_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE) && !upd_ack_s;
    assign busy         = (state_q != S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_status   = status_q;
    assign async_enable = en_q;
    assign async_update = upd_q;
    assign mfi          = mfi_q;
    assign mfn          = mfn_q;
    assign mfd          = mfd_q;

endmodule

// File: doc/clock_route_div_cfg_requester.md
Name: clock_route_div_cfg_requester

Overview:
Initiator side of the fractional clock-divider configuration interface. Runs in the configuration (register) clock domain. Accepts one-at-a-time commands from a register block, drives stable mfi/mfn/mfd plus level async_update/async_enable to the divider controller in the divided-source domain, and completes a four-phase handshake against async_update_ack/async_enable_ack. Returns a one-cycle status pulse per command.

Parameters:
TIMEOUT_CYCLES, 1024, max config-clock cycles spent in any wait state before aborting with TIMEOUT
CNT_W, 16, timeout counter width; must hold TIMEOUT_CYCLES-1

Ports:
clock  in  1  configuration clock, posedge
async_resetn  in  1  reset, asynchronous, active-low
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid & req_ready
req_op  in  2  00 UPDATE, 01 ENABLE, 10 DISABLE, 11 reserved
req_mfi  in  8  integer divide part (UPDATE only)
req_mfn  in  8  fractional numerator (UPDATE only)
req_mfd  in  8  fractional denominator (UPDATE only)
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_status  out  2  00 OK, 01 BAD_CFG, 10 TIMEOUT, 11 BAD_OP; valid with rsp_valid
busy  out  1  high whenever state != IDLE
async_enable  out  1  level enable to divider
async_enable_ack  in  1  divider enable acknowledge, asynchronous
async_update  out  1  level update request to divider
async_update_ack  in  1  divider update acknowledge, asynchronous
mfi, mfn, mfd  out  8 each  registered ratio to divider

Behaviour:
- Reset: state IDLE; async_enable, async_update, rsp_valid = 0; rsp_status = 00; mfi/mfn/mfd = 0; timeout counter = 0; synchronizers cleared. Reset mid-handshake aborts silently with no rsp_valid.
- Both ack inputs pass through 2-flop synchronizers before use: en_ack_s, upd_ack_s.
- req_ready = (state == IDLE) & ~upd_ack_s. A new command is never accepted while the divider still shows the previous update ack.
- States: IDLE, UPD_SETUP, UPD_RAISE, UPD_LOWER, EN_WAIT, RESP.
- IDLE, command accepted at cycle N:
  - UPDATE with bad config: respond BAD_CFG, outputs unchanged. Bad means mfi == 0; or mfd == 0 and mfn != 0; or mfd != 0 and mfn >= mfd.
  - UPDATE, valid: latch mfi/mfn/mfd (visible N+1), go to UPD_SETUP.
  - ENABLE/DISABLE: async_enable <= 1/0 (visible N+1), go to EN_WAIT.
  - 11: respond BAD_OP.
- UPD_SETUP: one cycle so data leads the request. Sets async_update = 1 (visible N+2), goes to UPD_RAISE.
- UPD_RAISE: wait for upd_ack_s == 1, then async_update <= 0 and go to UPD_LOWER.
- UPD_LOWER: wait for upd_ack_s == 0, then go to RESP with OK.
- mfi/mfn/mfd are held constant from N+1 until the next accepted UPDATE. They never change while async_update or upd_ack_s is high.
- EN_WAIT: wait for en_ack_s == async_enable, then RESP with OK. If the value already matches (same-state request), RESP is reached the cycle after entry.
- The timeout counter clears on entering each wait state (UPD_RAISE, UPD_LOWER, EN_WAIT) and increments while waiting. At TIMEOUT_CYCLES-1 without the exit condition:
  - Force async_update = 0 and go to RESP with TIMEOUT.
  - async_enable keeps the requested value.
  - If the ack later rises, req_ready stays low until it falls again.
- RESP: rsp_valid = 1 for exactly one cycle with rsp_status, then IDLE. BAD_CFG/BAD_OP responses are at N+1.
- Error-free UPDATE latency: rsp_valid no earlier than N+3 plus the synchronizer and divider round trip in both directions.
- req_* inputs are ignored when not accepted. busy and req_ready are mutually exclusive except when IDLE is blocked by upd_ack_s.

Decomposition:
- Package clock_route_div_pkg holds:
  - typedef enum for req_op (UPDATE, ENABLE, DISABLE, RSVD);
  - typedef enum for rsp_status (OK, BAD_CFG, TIMEOUT, BAD_OP);
  - state enum;
  - constant RATIO_W = 8.
- Sub-module: reuse clock_logic_cross_sync_0, two instances (enable ack, update ack). No new sub-module.

Test Plan:
- Model a divider that acks update 5 cycles after seeing async_update and drops the ack 5 cycles after it falls. UPDATE mfi=4, mfn=1, mfd=3 -> mfi/mfn/mfd = 4/1/3 at N+1, async_update high at N+2, single rsp_valid with OK, req_ready low until upd_ack_s = 0.
- UPDATE mfi=0, or mfn=3 with mfd=3 -> rsp_valid at N+1 with BAD_CFG; async_update never rises; mfi/mfn/mfd unchanged.
- ENABLE with ack following after 8 cycles, then DISABLE -> async_enable 1 then 0; each command returns OK after en_ack_s matches. A second ENABLE while already enabled -> OK within 3 cycles.
- Divider never acks UPDATE, TIMEOUT_CYCLES = 16 -> async_update drops after 16 wait cycles, status TIMEOUT. Late ack pulse arrives -> req_ready stays low until the ack clears, then a new command is accepted.
- Pulse async_resetn low during UPD_RAISE -> all outputs return to reset values, no rsp_valid, IDLE accepts the next command.
- req_op = 11 -> BAD_OP at N+1; no change on async_enable, async_update, or the ratio outputs.
